hidden_cpu_sequencer: RTL

//  Program store and instruction sequencer for the HiddenCPU core. A host loads
//  a short program of 6-bit instructions {opcode[1:0], addrs[3:0]} into an

---
 rtl/hidden_cpu_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hidden_cpu_sequencer.sv
// rtl/hidden_cpu_sequencer.sv - program store and instruction sequencer for the HiddenCPU core
module hidden_cpu_sequencer #(
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 4,
   parameter int INSTR_W     = 6,
   parameter int CYCLE_LIMIT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_en,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_data,
   output logic               load_ready,
   input  logic               run_start,
   input  logic               step_mode,
   input  logic               step_req,
   output logic [INSTR_W-1:0] cpu_instr,
   output logic               cpu_instr_valid,
   input  logic               cpu_branch,
   input  logic [7:0]         cpu_offset,
   output logic [ADDR_W-1:0]  pc_out,
   output logic [1:0]         state_out,
   output logic               done,
   output logic               err
);

   localparam int CNT_W = $clog2(CYCLE_LIMIT + 1);
   // Branch targets are formed as 9-bit signed values: 8-bit offset plus sign headroom.
   localparam int TGT_W = 9;
   localparam logic [ADDR_W:0] PTR_ONE    = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] DEPTH_V    = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(CYCLE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_HALT = 2'b11
   } state_t;

   state_t               state_q;
   logic [INSTR_W-1:0]   mem_q [DEPTH];
   logic [ADDR_W:0]      wr_ptr_q;
   logic [ADDR_W:0]      prog_len_q;
   logic [ADDR_W-1:0]    fptr_q;
   logic [ADDR_W-1:0]    pc_q;
   logic [CNT_W-1:0]     issue_cnt_q;
   logic [INSTR_W-1:0]   instr_q;
   logic                 valid_q;
   logic                 done_q;
   logic                 err_q;

   logic signed [TGT_W-1:0] tgt_d;
   logic signed [TGT_W-1:0] len_s;
   logic [ADDR_W-1:0]       fptr_d;
   logic                    tgt_end;
   logic                    tgt_bad;
   logic                    issue_req;
   logic                    wr_en;

   assign load_ready      = (state_q == S_LOAD) && (wr_ptr_q < DEPTH_V);
   assign cpu_instr       = instr_q;
   assign cpu_instr_valid = valid_q;
   assign pc_out          = pc_q;
   assign state_out       = state_q;
   assign done            = done_q;
   assign err             = err_q;

   // Next-fetch target from the live instruction, plus issue and buffer-write qualifiers.
   always_comb begin
      len_s = $signed({{(TGT_W-ADDR_W-1){1'b0}}, prog_len_q});
      if (cpu_branch) begin
         tgt_d = $signed({{(TGT_W-ADDR_W){1'b0}}, pc_q}) + $signed({cpu_offset[7], cpu_offset});
      end else begin
         tgt_d = $signed({{(TGT_W-ADDR_W){1'b0}}, pc_q}) + 9'sd1;
      end
      // Branch input only matters while an instruction is live on the pins.
      tgt_end   = valid_q && !cpu_branch && (tgt_d == len_s);
      tgt_bad   = valid_q && cpu_branch && ((tgt_d < 9'sd0) || (tgt_d >= len_s));
      fptr_d    = valid_q ? tgt_d[ADDR_W-1:0] : fptr_q;
      issue_req = step_mode ? step_req : 1'b1;
      wr_en     = !load_en && !run_start && (state_q == S_LOAD) && load_valid && load_ready;
   end

   // Program buffer: written only while loading, contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= load_data;
      end
   end

   // Sequencer FSM: load_en beats run_start beats the current state's own activity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         prog_len_q  <= '0;
         fptr_q      <= '0;
         pc_q        <= '0;
         issue_cnt_q <= '0;
         instr_q     <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else if (load_en) begin
         state_q    <= S_LOAD;
         wr_ptr_q   <= '0;
         prog_len_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else if (run_start) begin
         valid_q <= 1'b0;
         if (prog_len_q == '0) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
         end else begin
            state_q     <= S_RUN;
            fptr_q      <= '0;
            issue_cnt_q <= '0;
            done_q      <= 1'b0;
         end
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_LOAD: begin
               if (load_valid) begin
                  if (load_ready) begin
                     wr_ptr_q   <= wr_ptr_q + PTR_ONE;
                     prog_len_q <= wr_ptr_q + PTR_ONE;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (tgt_end) begin
                  state_q <= S_HALT;
                  done_q  <= 1'b1;
               end else if (tgt_bad) begin
                  state_q <= S_HALT;
                  err_q   <= 1'b1;
               end else begin
                  // Pointer update and next issue share a cycle, so there is no bubble.
                  fptr_q <= fptr_d;
                  if (issue_req) begin
                     if (issue_cnt_q == CNT_LIMIT) begin
                        state_q <= S_HALT;
                        err_q   <= 1'b1;
                     end else begin
                        valid_q     <= 1'b1;
                        instr_q     <= mem_q[fptr_d];
                        pc_q        <= fptr_d;
                        issue_cnt_q <= issue_cnt_q + CNT_ONE;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
